ysyx_22041412_muldiv_iter: RTL and testbench
============================================

Name: ysyx_22041412_muldiv_iter

Overview:
Iterative, parametrised RV64M/RV32M multiply/divide unit for the EXU. It replaces the single-cycle combinational mul/div. The unit covers all eight M-extension func3 encodings plus the RV64 word variants, computing one bit per cycle (radix-2 shift-add multiply, restoring divide). It uses valid/ready handshakes on both sides so the pipeline can stall on it, and supports flush for redirect/trap.

Parameters:
XLEN, 64, datapath width (32 or 64).
SUPPORT_WORD, 1, enables *W ops (is_word); when 0, is_word is ignored.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  abort current op; highest priority after rst
in_valid  in  1  request valid
in_ready  out  1  unit can accept (state IDLE)
func3  in  3  M-ext func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
is_word  in  1  *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock and one reset. clk is the clock. rst is synchronous and active-high, sampled on posedge clk. After rst: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1, iteration counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands/op. Go to SPEC if special, else CALC.
  - CALC: one iteration per cycle for ITER cycles. ITER=32 if is_word&&SUPPORT_WORD, else XLEN.
  - FIX: apply sign correction, select hi/lo/quotient/remainder, register result.
  - SPEC: register special-case result.
  - DONE: out_valid=1, result stable. On out_ready, go to IDLE.
- Latency (accept edge = edge 0):
  - Normal ops: out_valid rises after edge ITER+1.
  - Special ops: out_valid rises after edge 1.
  - No accept while DONE. Back-to-back issue is possible the cycle after out_ready handshake.
- Operand prep:
  - Signed ops use magnitudes; the sign is applied in FIX.
  - MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both unsigned.
  - Word ops use rs[31:0], sign-extended for MULW/DIVW/REMW and zero-extended for DIVUW/REMUW. The 32-bit result is sign-extended from bit 31 to XLEN.
- Results:
  - MUL: low XLEN of product. MULH*: high XLEN of the 2*XLEN product.
  - DIV: quotient rounds toward zero. REM: sign follows dividend.
- Special cases (SPEC path):
  - Divisor==0: quotient=all ones; remainder=dividend (after word extension).
  - Signed overflow, i.e. dividend=most negative and divisor=-1 (32-bit check for word ops): quotient=dividend, remainder=0.
  - is_word with func3 001/010/011 (illegal): result=0.
  - Multiply never takes SPEC.
- flush:
  - In any state, flush forces IDLE next edge, drops out_valid, and discards the op; result holds its old value.
  - If flush and in_valid arrive together in IDLE, the request is not accepted.
- rst mid-operation: same as reset values; no partial result is emitted.
- Counter is log2(XLEN)+1 bits; it never wraps past ITER.
- Operands are captured on accept; input changes during CALC have no effect.

Test Plan:
- MUL XLEN=64: rs1=7, rs2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 65 edges after accept.
- MULH/MULHU/MULHSU with rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> 0x0000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFE / 0xFFFF_FFFF_FFFF_FFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
- Specials: DIV x/0 (x=5) -> all ones, REM -> 5, out_valid after 1 edge. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0. DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Word ops: MULW 0x0001_0000 * 0x0001_0000 -> 0; DIVUW rs1=0xFFFF_FFFF_FFFF_FFFE, rs2=2 -> 0x0000_0000_7FFF_FFFF (wait: 0xFFFF_FFFE/2=0x7FFF_FFFF, sign-ext positive); out_valid 33 edges after accept.
- Control: hold out_ready=0 for 5 cycles -> out_valid/result stable, in_ready=0. Assert flush mid-CALC -> IDLE next edge, no out_valid. Assert rst mid-CALC -> all outputs at reset values next edge. A new op accepted next cycle completes correctly.

Source files
------------

// File: rtl/ysyx_22041412_muldiv_iter_if.sv
// Request/response bundle between the EXU and the iterative multiply/divide unit.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1; the
//   producer holds valid and payload stable until that edge (flush is the only way to retract).
interface ysyx_22041412_muldiv_iter_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      func3;
    logic            is_word;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, func3, is_word, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, func3, is_word, rs1, rs2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22041412_muldiv_iter.sv
// Iterative RV64M/RV32M multiply/divide: one bit per cycle, radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and special cases resolved up front.
module ysyx_22041412_muldiv_iter #(
    parameter int XLEN         = 64,
    parameter bit SUPPORT_WORD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    ysyx_22041412_muldiv_iter_if.slave io,
    output logic [2:0]                 dbg_state
);
    localparam int              CW        = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   ITER_FULL = CW'(XLEN);
    localparam logic [CW-1:0]   ITER_WORD = CW'(32);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        SPEC = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Latched operation and working registers.
    logic [XLEN-1:0] hi, lo, opnd, result_q;
    logic [CW-1:0]   cnt;
    logic            op_word, op_div, op_rem, op_high, neg_q, neg_r;

    // Request decode, evaluated combinationally on the incoming operands.
    logic            req_word, req_s1, req_s2, req_div, req_rem, req_uext;
    logic [XLEN-1:0] x1, x2, mag1, mag2, spec_val;
    logic            neg1, neg2, div0, ovf, illegal, special, accept;

    always_comb begin
        req_word = SUPPORT_WORD && io.is_word;
        req_div  = io.func3[2];
        req_rem  = io.func3[1];
        req_s1   = (io.func3 == 3'b001) || (io.func3 == 3'b010) ||
                   (io.func3 == 3'b100) || (io.func3 == 3'b110);
        req_s2   = (io.func3 == 3'b001) || (io.func3 == 3'b100) || (io.func3 == 3'b110);
        req_uext = (io.func3 == 3'b101) || (io.func3 == 3'b111);

        x1 = io.rs1;
        x2 = io.rs2;
        if (req_word) begin
            x1 = req_uext ? zext32(io.rs1[31:0]) : sext32(io.rs1[31:0]);
            x2 = req_uext ? zext32(io.rs2[31:0]) : sext32(io.rs2[31:0]);
        end

        neg1 = req_s1 && x1[XLEN-1];
        neg2 = req_s2 && x2[XLEN-1];
        mag1 = neg1 ? -x1 : x1;
        mag2 = neg2 ? -x2 : x2;

        div0    = (x2 == '0);
        // Word overflow is judged on the 32-bit operands, not their extensions.
        ovf     = ((io.func3 == 3'b100) || (io.func3 == 3'b110)) &&
                  (req_word ? ((x1[31:0] == 32'h8000_0000) && (x2[31:0] == 32'hFFFF_FFFF))
                            : ((x1 == MOST_NEG) && (&x2)));
        illegal = req_word && !req_div && (io.func3[1:0] != 2'b00);
        special = illegal || (req_div && (div0 || ovf));

        spec_val = '0;
        if (!illegal) begin
            if (div0) spec_val = req_rem ? x1 : '1;
            else      spec_val = req_rem ? '0 : x1;
            if (req_word) spec_val = sext32(spec_val[31:0]);
        end

        accept = (state == IDLE) && io.in_valid && !flush;
    end

    // One iteration of each algorithm.
    logic [XLEN:0] mul_sum, div_rs, div_diff;
    logic          div_ge, iter_last;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_rs   = {hi, lo[XLEN-1]};
        div_diff = div_rs - {1'b0, opnd};
        // The partial remainder stays below the divisor, so the top bit is a clean borrow.
        div_ge    = !div_diff[XLEN];
        iter_last = (cnt == ((op_word ? ITER_WORD : ITER_FULL) - CW'(1)));
    end

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo, rem, div_sel, mul_sel, fix_val;

    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? -prod : prod;
        // After 32 steps the word product's low half sits just below the register midpoint.
        if (op_high)      mul_sel = prod_fix[2*XLEN-1:XLEN];
        else if (op_word) mul_sel = sext32(prod_fix[XLEN-1 -: 32]);
        else              mul_sel = prod_fix[XLEN-1:0];

        quo     = neg_q ? -lo : lo;
        rem     = neg_r ? -hi : hi;
        div_sel = op_rem ? rem : quo;
        fix_val = op_div ? (op_word ? sext32(div_sel[31:0]) : div_sel) : mul_sel;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? SPEC : CALC;
            CALC:    if (iter_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            SPEC:    state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            op_word  <= 1'b0;
            op_div   <= 1'b0;
            op_rem   <= 1'b0;
            op_high  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt     <= '0;
                    op_word <= req_word;
                    op_div  <= req_div;
                    op_rem  <= req_rem;
                    op_high <= (io.func3[1:0] != 2'b00);
                    neg_q   <= neg1 ^ neg2;
                    neg_r   <= neg1;
                    hi      <= special ? spec_val : '0;
                    if (req_div) begin
                        // Word dividends start at the top so 32 shifts consume all their bits.
                        lo   <= req_word ? (mag1 << (XLEN - 32)) : mag1;
                        opnd <= mag2;
                    end else begin
                        lo   <= mag2;
                        opnd <= mag1;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op_div) begin
                        hi <= div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                    end
                end
                FIX:     result_q <= fix_val;
                SPEC:    result_q <= hi;
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.busy      = (state != IDLE);
    assign io.out_valid = (state == DONE);
    assign io.result    = result_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_ysyx_22041412_muldiv_iter.sv
// Bench for the iterative multiply/divide unit: directed spec vectors, randomized ops against
// a wide-arithmetic reference model, backpressure, flush, mid-op reset and back-to-back issue.
module tb_ysyx_22041412_muldiv_iter;
    localparam int XLEN = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] dbg_state;

    ysyx_22041412_muldiv_iter_if #(.XLEN(XLEN)) io ();

    ysyx_22041412_muldiv_iter #(.XLEN(XLEN), .SUPPORT_WORD(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .io        (io),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e;
        int          lat;
    } vec_t;

    // Reference model: RISC-V M semantics computed with wide native arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        int                  a32s, b32s;
        int unsigned         a32u, b32u;
        longint              as, bs;
        logic [31:0]         r32;
        if (w) begin
            a32s = a[31:0];
            b32s = b[31:0];
            a32u = a[31:0];
            b32u = b[31:0];
            case (f)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: r32 = (b32s == 0) ? 32'hFFFF_FFFF :
                            ((a32s == 32'sh8000_0000 && b32s == -1) ? a[31:0] : 32'(a32s / b32s));
                3'd5: r32 = (b32u == 0) ? 32'hFFFF_FFFF : 32'(a32u / b32u);
                3'd6: r32 = (b32s == 0) ? a[31:0] :
                            ((a32s == 32'sh8000_0000 && b32s == -1) ? 32'd0 : 32'(a32s % b32s));
                3'd7: r32 = (b32u == 0) ? a[31:0] : 32'(a32u % b32u);
                default: r32 = 32'd0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'd0, a};
        ub = {64'd0, b};
        as = a;
        bs = b;
        case (f)
            3'd0: begin p = ua * ub; return p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
                return 64'(as / bs);
            end
            3'd5: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: begin
                if (b == 64'd0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
                return 64'(as % bs);
            end
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    // Expected accept-to-out_valid edge count from the special-case and iteration rules.
    function automatic int exp_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf, spec;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = ((f == 3'd4) || (f == 3'd6)) &&
               (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        spec = (w && !f[2] && f[1:0] != 2'b00) || (f[2] && (zero || ovf));
        return spec ? 1 : (w ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive_req(input logic [2:0] f, input logic w,
                             input logic [63:0] a, input logic [63:0] b);
        io.in_valid = 1'b1;
        io.func3    = f;
        io.is_word  = w;
        io.rs1      = a;
        io.rs2      = b;
    endtask

    // Issue one op, scramble the inputs after accept, wait for out_valid, then consume it.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clk);
        drive_req(f, w, a, b);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.func3    = 3'($urandom);
        io.is_word  = 1'($urandom);
        io.rs1      = {$urandom, $urandom};
        io.rs2      = {$urandom, $urandom};
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = io.result;
        if (lat >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_op timeout f3=%0d w=%0d out_valid got %b want 1", f, w, io.out_valid);
        end
        @(negedge clk);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.func3     = 3'd0;
        io.is_word   = 1'b0;
        io.rs1       = '0;
        io.rs2       = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", io.out_valid); end
        n_cmp++; if (io.result !== 64'd0) begin n_fail++; $display("FAIL reset result got %h want 0", io.result); end
        n_cmp++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", io.busy); end
        n_cmp++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", io.in_ready); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset dbg_state got %0d want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        v[20];
        logic [63:0] res;
        int          lat;
        v[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        v[1]  = '{3'd1, 1'b0, '1, '1, 64'd0, 65};
        v[2]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        v[3]  = '{3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        v[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        v[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        v[6]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        v[7]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        v[8]  = '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        v[9]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        v[10] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        v[11] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
        v[12] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        v[13] = '{3'd0, 1'b1, 64'h0001_0000, 64'h0001_0000, 64'd0, 33};
        v[14] = '{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
        v[15] = '{3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 1};
        v[16] = '{3'd7, 1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1};
        v[17] = '{3'd5, 1'b1, 64'd1, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        v[18] = '{3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        v[19] = '{3'd0, 1'b1, 64'h1234_5678_0000_0003, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        for (int i = 0; i < 20; i++) begin
            run_op(v[i].f, v[i].w, v[i].a, v[i].b, res, lat);
            n_cmp++;
            if (res !== v[i].e) begin
                n_fail++;
                $display("FAIL dir[%0d] result f3=%0d w=%0d got %h want %h", i, v[i].f, v[i].w, res, v[i].e);
            end
            n_cmp++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL dir[%0d] latency got %0d want %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b, res, e;
        int          lat;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom);
            w = ($urandom_range(0, 3) == 0);
            a = pick();
            b = pick();
            exp_q.push_back(model(f, w, a, b));
            run_op(f, w, a, b, res, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (res !== e) begin
                n_fail++;
                $display("FAIL rand[%0d] f3=%0d w=%0d a=%h b=%h result got %h want %h", i, f, w, a, b, res, e);
            end
            n_cmp++;
            if (lat != exp_lat(f, w, a, b)) begin
                n_fail++;
                $display("FAIL rand[%0d] latency got %0d want %0d", i, lat, exp_lat(f, w, a, b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, e, held;
        int          k;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = model(3'd3, 1'b0, a, b);
        @(negedge clk);
        drive_req(3'd3, 1'b0, a, b);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        k = 0;
        while (io.out_valid !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        held = io.result;
        n_cmp++;
        if (held !== e) begin n_fail++; $display("FAIL bp result got %h want %h", held, e); end
        @(negedge clk);
        drive_req(3'd5, 1'b0, 64'd9, 64'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
            n_cmp++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid got %b want 1", io.out_valid); end
            n_cmp++; if (io.result !== e) begin n_fail++; $display("FAIL bp hold result got %h want %h", io.result, e); end
            n_cmp++; if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready got %b want 0", io.in_ready); end
        end
        @(negedge clk);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        n_cmp++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release out_valid got %b want 0", io.out_valid); end
        n_cmp++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready got %b want 1", io.in_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] prev, a, b, res;
        int          lat, seen;
        prev = io.result;
        a = {$urandom, $urandom};
        b = 64'($urandom_range(1, 1000));
        @(negedge clk);
        drive_req(3'd4, 1'b0, a, b);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid got %b want 0", io.out_valid); end
        n_cmp++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL flush busy got %b want 0", io.busy); end
        n_cmp++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready got %b want 1", io.in_ready); end
        n_cmp++; if (io.result !== prev) begin n_fail++; $display("FAIL flush result got %h want %h", io.result, prev); end
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (io.out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL flush late out_valid got %0d cycles want 0", seen); end
        @(negedge clk);
        flush = 1'b1;
        drive_req(3'd0, 1'b0, 64'd3, 64'd4);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        io.in_valid = 1'b0;
        n_cmp++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept busy got %b want 0", io.busy); end
        run_op(3'd6, 1'b0, a, b, res, lat);
        n_cmp++; if (res !== model(3'd6, 1'b0, a, b)) begin n_fail++; $display("FAIL flush_after result got %h want %h", res, model(3'd6, 1'b0, a, b)); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] a, b, res;
        int          lat;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        @(negedge clk);
        drive_req(3'd1, 1'b0, a, b);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid out_valid got %b want 0", io.out_valid); end
        n_cmp++; if (io.result !== 64'd0) begin n_fail++; $display("FAIL rst_mid result got %h want 0", io.result); end
        n_cmp++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b want 0", io.busy); end
        n_cmp++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid in_ready got %b want 1", io.in_ready); end
        run_op(3'd2, 1'b0, a, b, res, lat);
        n_cmp++; if (res !== model(3'd2, 1'b0, a, b)) begin n_fail++; $display("FAIL rst_after result got %h want %h", res, model(3'd2, 1'b0, a, b)); end
        n_cmp++; if (lat != 65) begin n_fail++; $display("FAIL rst_after latency got %0d want 65", lat); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [63:0] a, b, res, e;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            f = 3'(i + 4);
            a = {$urandom, $urandom};
            b = {32'd0, $urandom} | 64'd1;
            exp_q.push_back(model(f, 1'b0, a, b));
            run_op(f, 1'b0, a, b, res, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (res !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] f3=%0d result got %h want %h", i, f, res, e);
            end
            n_cmp++;
            if (lat != 65) begin
                n_fail++;
                $display("FAIL b2b[%0d] latency got %0d want 65", i, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(40);
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
